// File: rtl/pong_pkg.sv
// Shared definitions for the Pong paddle renderers: screen geometry,
// paddle dimensions, coordinate width and the per-frame update FSM states.
package pong_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PADDLE_W = 10;
  localparam int PADDLE_H = 80;
  localparam int COORD_W  = 10;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    LATCH  = 2'd1,
    STEP   = 2'd2
  } paddle_state_e;

endpackage

// File: rtl/pong_paddle_renderer.sv
// Paddle renderer: samples the requested paddle Y once per frame at the
// start of vertical blanking, clamps it to the playfield, slews the displayed
// Y toward it by a bounded step, and produces a registered per-pixel hit.
// The left paddle reuses this module with a different PADDLE_X.
module pong_paddle_renderer #(
  parameter int PADDLE_X = 600,
  parameter int PADDLE_W = pong_pkg::PADDLE_W,
  parameter int PADDLE_H = pong_pkg::PADDLE_H,
  parameter int SCREEN_H = pong_pkg::SCREEN_H,
  parameter int MAX_STEP = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] target_y,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       vblank,
  output logic       pixel_on,
  output logic [9:0] cur_y,
  output logic       moving
);

  import pong_pkg::*;

  // All geometry compares are done in 11 bits so the bottom/right edges never wrap.
  localparam logic [10:0]        Y_MAX    = 11'(SCREEN_H - PADDLE_H);
  localparam logic [9:0]         Y_RESET  = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [10:0]        X_LO     = 11'(PADDLE_X);
  localparam logic [10:0]        X_HI     = 11'(PADDLE_X + PADDLE_W - 1);
  localparam logic [10:0]        H_M1     = 11'(PADDLE_H - 1);
  localparam logic signed [10:0] STEP_POS = 11'(MAX_STEP);
  localparam logic signed [10:0] STEP_NEG = 11'(-MAX_STEP);
  localparam logic [9:0]         STEP_10  = 10'(MAX_STEP);

  paddle_state_e      state_r;
  logic               vblank_d_r;
  logic [9:0]         tgt_q_r;
  logic [9:0]         cur_y_r;
  logic               moving_r;
  logic               pixel_on_r;

  logic [9:0]         clamp_s;
  logic signed [10:0] diff_s;
  logic [9:0]         next_y_s;
  logic [10:0]        y_bot_s;
  logic               hit_s;

  // Clamp the request, compute the bounded slew target and the pixel hit.
  always_comb begin
    clamp_s  = target_y;
    diff_s   = 11'sd0;
    next_y_s = cur_y_r;
    y_bot_s  = 11'd0;
    hit_s    = 1'b0;

    if ({1'b0, target_y} > Y_MAX) begin
      clamp_s = Y_MAX[9:0];
    end else begin
      clamp_s = target_y;
    end

    diff_s = $signed({1'b0, tgt_q_r}) - $signed({1'b0, cur_y_r});
    if ((diff_s <= STEP_POS) && (diff_s >= STEP_NEG)) begin
      next_y_s = tgt_q_r;
    end else if (diff_s > 11'sd0) begin
      next_y_s = cur_y_r + STEP_10;
    end else begin
      next_y_s = cur_y_r - STEP_10;
    end

    y_bot_s = {1'b0, cur_y_r} + H_M1;
    hit_s   = video_on
            && ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} <= X_HI)
            && ({1'b0, pixel_y} >= {1'b0, cur_y_r}) && ({1'b0, pixel_y} <= y_bot_s);
  end

  // Per-frame update FSM: detect vblank rise, latch the request, take one slew step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ACTIVE;
      vblank_d_r <= 1'b0;
      tgt_q_r    <= Y_RESET;
      cur_y_r    <= Y_RESET;
      moving_r   <= 1'b0;
    end else begin
      // Tracked every cycle, so an edge that arrives mid-update is consumed, not deferred.
      vblank_d_r <= vblank;
      case (state_r)
        ACTIVE: begin
          if (vblank && !vblank_d_r) begin
            state_r <= LATCH;
          end else begin
            state_r <= ACTIVE;
          end
        end
        LATCH: begin
          tgt_q_r <= clamp_s;
          state_r <= STEP;
        end
        STEP: begin
          cur_y_r  <= next_y_s;
          moving_r <= (next_y_s != tgt_q_r);
          state_r  <= ACTIVE;
        end
        default: begin
          state_r <= ACTIVE;
        end
      endcase
    end
  end

  // Register the pixel hit so the colour mux sees a clean, one-cycle-late flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_on_r <= 1'b0;
    end else begin
      pixel_on_r <= hit_s;
    end
  end

  assign pixel_on = pixel_on_r;
  assign cur_y    = cur_y_r;
  assign moving   = moving_r;

endmodule

// File: tb/tb_pong_paddle_renderer.sv
// Self-checking bench for pong_paddle_renderer: expected paddle positions and
// pixel hits are pushed to scoreboard queues as stimulus is applied and popped
// when the corresponding DUT output is due.
module tb_pong_paddle_renderer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] target_y;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       vblank;
  logic       pixel_on;
  logic [9:0] cur_y;
  logic       moving;

  int checks = 0;
  int errors = 0;
  int model_cur = 200;
  int model_tgt = 200;
  int exp_cur_q[$];
  int exp_mov_q[$];
  int exp_pix_q[$];

  pong_paddle_renderer #(.PADDLE_X(600)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .target_y (target_y),
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .video_on (video_on),
    .vblank   (vblank),
    .pixel_on (pixel_on),
    .cur_y    (cur_y),
    .moving   (moving)
  );

  always #5 clk = ~clk;

  function automatic int clampv(input int t);
    return (t > 400) ? 400 : t;
  endfunction

  function automatic int stepv(input int c, input int t);
    int d;
    d = t - c;
    if (d <= 8 && d >= -8) return t;
    else if (d > 0) return c + 8;
    else return c - 8;
  endfunction

  // One frame's worth of vblank with a fixed request; expected results go to the scoreboard.
  task automatic run_frame(input int ty);
    model_tgt = clampv(ty);
    model_cur = stepv(model_cur, model_tgt);
    exp_cur_q.push_back(model_cur);
    exp_mov_q.push_back(model_cur != model_tgt ? 1 : 0);
    target_y = 10'(ty);
    vblank = 1'b1;
    repeat (4) @(posedge clk);
    #1 vblank = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // vblank frame where target_y alternates every cycle; only the value present at LATCH counts.
  task automatic toggle_frame(input int latched, input int other);
    model_tgt = clampv(latched);
    model_cur = stepv(model_cur, model_tgt);
    exp_cur_q.push_back(model_cur);
    exp_mov_q.push_back(model_cur != model_tgt ? 1 : 0);
    vblank = 1'b1;
    target_y = 10'(other);
    @(posedge clk); #1;
    target_y = 10'(latched);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      target_y = (i % 2 == 0) ? 10'(other) : 10'(latched);
    end
    vblank = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int e;
    reset_n = 1'b0; vblank = 1'b0; video_on = 1'b1;
    pixel_x = 10'd605; pixel_y = 10'd240; target_y = 10'd300;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cur_y !== 10'd200) begin errors++; $display("FAIL reset_cur_y got %0d expected 200", cur_y); end
    checks++; if (pixel_on !== 1'b0) begin errors++; $display("FAIL reset_pixel_on got %0b expected 0", pixel_on); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL reset_moving got %0b expected 0", moving); end
    @(negedge clk) reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    e = model_cur;
    checks++; if (cur_y !== 10'(e)) begin errors++; $display("FAIL release_no_update got %0d expected %0d", cur_y, e); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL release_moving got %0b expected 0", moving); end
  endtask

  task automatic test_hit();
    int vx[8] = '{600, 609, 610, 599, 605, 605, 605, 605};
    int vy[8] = '{200, 279, 240, 240, 280, 240, 199, 240};
    int vo[8] = '{1,   1,   1,   1,   1,   0,   1,   1  };
    int ex[8] = '{1,   1,   0,   0,   0,   0,   0,   1  };
    int e;
    for (int i = 0; i < 8; i++) begin
      pixel_x = 10'(vx[i]); pixel_y = 10'(vy[i]); video_on = vo[i][0];
      exp_pix_q.push_back(ex[i]);
      @(posedge clk); #1;
      e = exp_pix_q.pop_front();
      checks++;
      if (pixel_on !== e[0]) begin
        errors++;
        $display("FAIL hit(%0d,%0d,von=%0d) got %0b expected %0d", vx[i], vy[i], vo[i], pixel_on, e);
      end
    end
    video_on = 1'b0;
  endtask

  task automatic test_slew();
    int e, m;
    for (int f = 0; f < 13; f++) begin
      run_frame(300);
      e = exp_cur_q.pop_front(); m = exp_mov_q.pop_front();
      if (f == 0 || f == 11 || f == 12) begin
        checks++; if (cur_y !== 10'(e)) begin errors++; $display("FAIL slew_cur frame %0d got %0d expected %0d", f, cur_y, e); end
        checks++; if (moving !== m[0]) begin errors++; $display("FAIL slew_moving frame %0d got %0b expected %0d", f, moving, m); end
      end
    end
  endtask

  task automatic test_clamp();
    int e, m;
    for (int f = 0; f < 15; f++) begin
      run_frame(1023);
      e = exp_cur_q.pop_front(); m = exp_mov_q.pop_front();
      checks++; if (cur_y !== 10'(e) || cur_y > 10'd400) begin errors++; $display("FAIL clamp_hi frame %0d got %0d expected %0d", f, cur_y, e); end
    end
    checks++; if (moving !== m[0]) begin errors++; $display("FAIL clamp_hi_moving got %0b expected %0d", moving, m); end
    for (int f = 0; f < 52; f++) begin
      run_frame(0);
      e = exp_cur_q.pop_front(); m = exp_mov_q.pop_front();
      checks++; if (cur_y !== 10'(e)) begin errors++; $display("FAIL clamp_lo frame %0d got %0d expected %0d", f, cur_y, e); end
    end
    checks++; if (moving !== m[0]) begin errors++; $display("FAIL clamp_lo_moving got %0b expected %0d", moving, m); end
  endtask

  task automatic test_timing();
    int e, m;
    for (int f = 0; f < 13; f++) begin
      run_frame(104);
      e = exp_cur_q.pop_front(); m = exp_mov_q.pop_front();
    end
    checks++; if (cur_y !== 10'(e)) begin errors++; $display("FAIL reach_104 got %0d expected %0d", cur_y, e); end
    toggle_frame(100, 300);
    e = exp_cur_q.pop_front(); m = exp_mov_q.pop_front();
    checks++; if (cur_y !== 10'(e)) begin errors++; $display("FAIL toggle_100 got %0d expected %0d", cur_y, e); end
    checks++; if (moving !== m[0]) begin errors++; $display("FAIL toggle_100_moving got %0b expected %0d", moving, m); end
    toggle_frame(300, 100);
    e = exp_cur_q.pop_front(); m = exp_mov_q.pop_front();
    checks++; if (cur_y !== 10'(e)) begin errors++; $display("FAIL toggle_300 got %0d expected %0d", cur_y, e); end
    checks++; if (moving !== m[0]) begin errors++; $display("FAIL toggle_300_moving got %0b expected %0d", moving, m); end
    // Long vblank: one update only, and a request change mid-hold is not picked up.
    model_tgt = 300;
    model_cur = stepv(model_cur, model_tgt);
    exp_cur_q.push_back(model_cur);
    target_y = 10'd300; vblank = 1'b1;
    repeat (100) @(posedge clk);
    #1 target_y = 10'd0;
    repeat (4900) @(posedge clk);
    #1 vblank = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    e = exp_cur_q.pop_front();
    checks++; if (cur_y !== 10'(e)) begin errors++; $display("FAIL long_vblank got %0d expected %0d", cur_y, e); end
    checks++; if (moving !== 1'b1) begin errors++; $display("FAIL long_vblank_moving got %0b expected 1", moving); end
  endtask

  task automatic test_async_reset();
    int e, m;
    // Reset during the LATCH cycle.
    target_y = 10'd0; vblank = 1'b1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++; if (cur_y !== 10'd200 || moving !== 1'b0 || pixel_on !== 1'b0) begin
      errors++; $display("FAIL reset_in_latch got cur_y=%0d moving=%0b pixel_on=%0b expected 200/0/0", cur_y, moving, pixel_on);
    end
    vblank = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    model_cur = 200; model_tgt = 200;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (cur_y !== 10'd200) begin errors++; $display("FAIL after_latch_reset got %0d expected 200", cur_y); end
    // Move off 200, then reset during the STEP cycle.
    run_frame(300);
    e = exp_cur_q.pop_front(); m = exp_mov_q.pop_front();
    checks++; if (cur_y !== 10'(e)) begin errors++; $display("FAIL pre_step_reset got %0d expected %0d", cur_y, e); end
    target_y = 10'd0; vblank = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++; if (cur_y !== 10'd200 || moving !== 1'b0) begin
      errors++; $display("FAIL reset_in_step got cur_y=%0d moving=%0b expected 200/0", cur_y, moving);
    end
    vblank = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    model_cur = 200; model_tgt = 200;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (cur_y !== 10'd200 || moving !== 1'b0) begin
      errors++; $display("FAIL after_step_reset got cur_y=%0d moving=%0b expected 200/0", cur_y, moving);
    end
    run_frame(200);
    e = exp_cur_q.pop_front(); m = exp_mov_q.pop_front();
    checks++; if (cur_y !== 10'(e) || moving !== m[0]) begin
      errors++; $display("FAIL post_reset_frame got cur_y=%0d moving=%0b expected %0d/%0d", cur_y, moving, e, m);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_slew();
    test_clamp();
    test_timing();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
